fpu_mul_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier with valid/ready handshakes on both sides. It is the responding end of the FPU multiply path. Upstream logic issues an operand pair, and the block returns the product plus the error, overflow and underflow flags after a fixed number of cycles. The flag encoding matches `fpu_top` multiplication mode, so `fpu_mul_seq` can replace the combinational multiplier wherever timing closure requires it.

---
 rtl/fpu_mul_seq.sv | 197 +++++++++++++++++++
 tb/tb_fpu_mul_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_seq.sv
// Multi-cycle FP32 multiplier with valid/ready handshakes, flush-to-zero and round-to-nearest-even.
// Define FPU_MUL_RADIX4_EN for a 2-bit-per-cycle multiply loop (12 iterations instead of 24).
module fpu_mul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        error,
  output logic        overflow,
  output logic        underflow
);

`ifdef FPU_MUL_RADIX4_EN
  localparam int N = 12;
`else
  localparam int N = 24;
`endif

  typedef enum logic [1:0] {IDLE, MUL, ROUND, DONE} state_t;

  state_t      state_reg;
  logic        sign_reg;
  logic [7:0]  ea_reg, eb_reg;
  logic [47:0] mcand_reg, prod_reg;
  logic [23:0] mplier_reg;
  logic [4:0]  cnt_reg;
`ifdef FPU_MUL_RADIX4_EN
  logic [47:0] mcand3_reg;
`endif

  assign in_ready = (state_reg == IDLE) && rst_n;

  // Operand classification, index 0 = a, index 1 = b
  logic [1:0][30:0] ops;
  logic [1:0]       is_zero, is_inf, is_nan;
  genvar gi;
  assign ops = {b[30:0], a[30:0]};
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      assign is_zero[gi] = (ops[gi][30:23] == 8'd0);
      assign is_inf[gi]  = (ops[gi][30:23] == 8'hFF) && (ops[gi][22:0] == 23'd0);
      assign is_nan[gi]  = (ops[gi][30:23] == 8'hFF) && (ops[gi][22:0] != 23'd0);
    end
  endgenerate

  logic        sign_in, special_in, spec_nan;
  logic [31:0] spec_result;
  logic [23:0] ma, mb;
  assign sign_in    = a[31] ^ b[31];
  assign special_in = (|is_zero) | (|is_inf) | (|is_nan);
  assign spec_nan   = (|is_nan) | (is_inf[0] & is_zero[1]) | (is_inf[1] & is_zero[0]);
  assign ma         = {1'b1, a[22:0]};
  assign mb         = {1'b1, b[22:0]};

  always_comb begin
    spec_result = {sign_in, 31'd0};
    if (spec_nan)
      spec_result = 32'h7FC0_0000;
    else if (|is_inf)
      spec_result = {sign_in, 8'hFF, 23'd0};
  end

  // One shift-add step of the multiply loop
  logic [47:0] addend, prod_next;
  always_comb begin
    addend = 48'd0;
`ifdef FPU_MUL_RADIX4_EN
    case (mplier_reg[1:0])
      2'd1:    addend = mcand_reg;
      2'd2:    addend = {mcand_reg[46:0], 1'b0};
      2'd3:    addend = mcand3_reg;
      default: addend = 48'd0;
    endcase
`else
    if (mplier_reg[0])
      addend = mcand_reg;
`endif
  end
  assign prod_next = prod_reg + addend;

  // Normalize, round to nearest even, range check
  logic signed [9:0] exp_sum, exp_adj, exp_fin;
  logic [23:0] mant;
  logic        guard_bit, sticky_bit, round_up;
  logic [24:0] mant_rnd;
  logic [22:0] frac_fin;
  logic        ovf, unf;
  logic [31:0] norm_result;

  assign exp_sum = $signed({2'b00, ea_reg}) + $signed({2'b00, eb_reg}) - 10'sd127;

  always_comb begin
    mant       = prod_reg[46:23];
    guard_bit  = prod_reg[22];
    sticky_bit = |prod_reg[21:0];
    exp_adj    = exp_sum;
    if (prod_reg[47]) begin
      mant       = prod_reg[47:24];
      guard_bit  = prod_reg[23];
      sticky_bit = |prod_reg[22:0];
      exp_adj    = exp_sum + 10'sd1;
    end
    round_up = guard_bit & (sticky_bit | mant[0]);
    mant_rnd = {1'b0, mant} + {24'd0, round_up};
    exp_fin  = exp_adj;
    frac_fin = mant_rnd[22:0];
    if (mant_rnd[24]) begin
      exp_fin  = exp_adj + 10'sd1;
      frac_fin = mant_rnd[23:1];
    end
    ovf = (exp_fin >= 10'sd255);
    unf = (exp_fin <= 10'sd0);
    if (ovf)
      norm_result = {sign_reg, 8'hFF, 23'd0};
    else if (unf)
      norm_result = {sign_reg, 31'd0};
    else
      norm_result = {sign_reg, exp_fin[7:0], frac_fin};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      result    <= 32'd0;
      error     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sign_reg   <= sign_in;
            ea_reg     <= a[30:23];
            eb_reg     <= b[30:23];
            mcand_reg  <= {24'd0, ma};
            mplier_reg <= mb;
            prod_reg   <= 48'd0;
            cnt_reg    <= 5'(N - 1);
`ifdef FPU_MUL_RADIX4_EN
            mcand3_reg <= {24'd0, ma} + {23'd0, ma, 1'b0};
`endif
            if (special_in) begin
              // out_valid follows one edge later from DONE
              result    <= spec_result;
              error     <= spec_nan;
              overflow  <= 1'b0;
              underflow <= 1'b0;
              state_reg <= DONE;
            end else begin
              state_reg <= MUL;
            end
          end
        end
        MUL: begin
          prod_reg <= prod_next;
`ifdef FPU_MUL_RADIX4_EN
          mcand_reg  <= {mcand_reg[45:0], 2'b00};
          mcand3_reg <= {mcand3_reg[45:0], 2'b00};
          mplier_reg <= {2'b00, mplier_reg[23:2]};
`else
          mcand_reg  <= {mcand_reg[46:0], 1'b0};
          mplier_reg <= {1'b0, mplier_reg[23:1]};
`endif
          if (cnt_reg == 5'd0)
            state_reg <= ROUND;
          else
            cnt_reg <= cnt_reg - 5'd1;
        end
        ROUND: begin
          result    <= norm_result;
          error     <= 1'b0;
          overflow  <= ovf;
          underflow <= unf & ~ovf;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Directed self-checking bench for fpu_mul_seq (hand-computed FP32 products and handshake timing).
module tb_fpu_mul_seq;

`ifdef FPU_MUL_RADIX4_EN
  localparam int N = 12;
`else
  localparam int N = 24;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        error, overflow, underflow;

  int n_checks = 0;
  int n_fail = 0;

  fpu_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .error(error), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Issues one operation and collects it; the bench always sits 1 time unit after a rising edge.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        output logic [31:0] r, output logic [2:0] flg, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 200) begin
      @(posedge clk); #1; wait_cnt++;
    end
    a = op_a; b = op_b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    r = result;
    flg = {error, overflow, underflow};
    $display("op a=%h b=%h -> result=%h e/o/u=%b latency=%0d", op_a, op_b, r, flg, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, error, overflow, underflow} !== 4'b0000 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got result=%h ov/e/o/u=%b, want 0 / 0000", result,
               {out_valid, error, overflow, underflow});
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready_release: got %b want 1", in_ready);
    end
  endtask

  // Normal-path vectors: product, flags and latency N+1
  task automatic test_normal;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    logic [2:0]  vf [8];
    logic [31:0] r;
    logic [2:0]  flg;
    int          lat;
    va[0] = 32'h4040_0000; vb[0] = 32'h4000_0000; vr[0] = 32'h40C0_0000; vf[0] = 3'b000;
    va[1] = 32'h3F80_0001; vb[1] = 32'h3F80_0001; vr[1] = 32'h3F80_0002; vf[1] = 3'b000;
    va[2] = 32'hC040_0000; vb[2] = 32'h4000_0000; vr[2] = 32'hC0C0_0000; vf[2] = 3'b000;
    va[3] = 32'h3FC0_0000; vb[3] = 32'h3F80_0001; vr[3] = 32'h3FC0_0002; vf[3] = 3'b000;
    va[4] = 32'h3FFF_FFFF; vb[4] = 32'h3FFF_FFFF; vr[4] = 32'h407F_FFFE; vf[4] = 3'b000;
    va[5] = 32'h7F00_0000; vb[5] = 32'h4000_0000; vr[5] = 32'h7F80_0000; vf[5] = 3'b010;
    va[6] = 32'h0080_0000; vb[6] = 32'h0080_0000; vr[6] = 32'h0000_0000; vf[6] = 3'b001;
    va[7] = 32'h3F80_0000; vb[7] = 32'hBF80_0000; vr[7] = 32'hBF80_0000; vf[7] = 3'b000;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], r, flg, lat);
      n_checks++;
      if (r !== vr[i]) begin
        n_fail++;
        $display("FAIL normal_result[%0d]: got %h want %h", i, r, vr[i]);
      end
      n_checks++;
      if (flg !== vf[i]) begin
        n_fail++;
        $display("FAIL normal_flags[%0d]: got %b want %b", i, flg, vf[i]);
      end
      n_checks++;
      if (lat !== N + 1) begin
        n_fail++;
        $display("FAIL normal_latency[%0d]: got %0d want %0d", i, lat, N + 1);
      end
    end
  endtask

  // Special operands: result, flags and latency 1
  task automatic test_special;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    logic [2:0]  vf [5];
    logic [31:0] r;
    logic [2:0]  flg;
    int          lat;
    va[0] = 32'hFFC0_0000; vb[0] = 32'h40A0_0000; vr[0] = 32'h7FC0_0000; vf[0] = 3'b100;
    va[1] = 32'h7F80_0000; vb[1] = 32'h0000_0000; vr[1] = 32'h7FC0_0000; vf[1] = 3'b100;
    va[2] = 32'h7F80_0000; vb[2] = 32'h7F80_0000; vr[2] = 32'h7F80_0000; vf[2] = 3'b000;
    va[3] = 32'h0000_0001; vb[3] = 32'h4000_0000; vr[3] = 32'h0000_0000; vf[3] = 3'b000;
    va[4] = 32'hFF80_0000; vb[4] = 32'h4000_0000; vr[4] = 32'hFF80_0000; vf[4] = 3'b000;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], r, flg, lat);
      n_checks++;
      if (r !== vr[i]) begin
        n_fail++;
        $display("FAIL special_result[%0d]: got %h want %h", i, r, vr[i]);
      end
      n_checks++;
      if (flg !== vf[i]) begin
        n_fail++;
        $display("FAIL special_flags[%0d]: got %b want %b", i, flg, vf[i]);
      end
      n_checks++;
      if (lat !== 1) begin
        n_fail++;
        $display("FAIL special_latency[%0d]: got %0d want 1", i, lat);
      end
    end
  endtask

  // out_ready held low with in_valid held high: output stable, nothing else accepted
  task automatic test_backpressure;
    int wait_cnt;
    a = 32'h4040_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h7F80_0000; b = 32'h0000_0000;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 200) begin
      @(posedge clk); #1; wait_cnt++;
    end
    n_checks++;
    if (wait_cnt !== N + 1) begin
      n_fail++;
      $display("FAIL backpressure_latency: got %0d want %0d", wait_cnt, N + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (result !== 32'h40C0_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got result=%h ov=%b ir=%b err=%b want 40c00000 1 0 0",
                 i, result, out_valid, in_ready, error);
      end
    end
    $display("held result=%h for 5 cycles", result);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [2:0]  flg;
    int          lat;
    run_op(32'h4000_0000, 32'h4000_0000, r, flg, lat);
    n_checks++;
    if (r !== 32'h4080_0000 || flg !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_first: got %h/%b want 40800000/000", r, flg);
    end
    run_op(32'h0000_0000, 32'hC000_0000, r, flg, lat);
    n_checks++;
    if (r !== 32'h8000_0000 || flg !== 3'b000 || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_second: got %h/%b lat %0d want 80000000/000 lat 1", r, flg, lat);
    end
  endtask

  // Reset pulse during MUL aborts the operation
  task automatic test_reset_mid_op;
    logic [31:0] r;
    logic [2:0]  flg;
    int          lat;
    int          seen;
    a = 32'h4040_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_handshake: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    n_checks++;
    if (result !== 32'd0 || {error, overflow, underflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h/%b want 00000000/000", result,
               {error, overflow, underflow});
    end
    seen = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_result: got %0d valid cycles want 0", seen);
    end
    run_op(32'h4040_0000, 32'h4000_0000, r, flg, lat);
    n_checks++;
    if (r !== 32'h40C0_0000 || lat !== N + 1) begin
      n_fail++;
      $display("FAIL midreset_recover: got %h lat %0d want 40c00000 lat %0d", r, lat, N + 1);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
